// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared codes for the core's bus datapath: write-select
//               codes, increment strobe bit positions and the DRAM write
//               handshake state encoding.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    // write_en codes
    localparam logic [3:0] WR_NONE   = 4'd0;
    localparam logic [3:0] WR_AR     = 4'd1;
    localparam logic [3:0] WR_I      = 4'd2;
    localparam logic [3:0] WR_J      = 4'd3;
    localparam logic [3:0] WR_K      = 4'd4;
    localparam logic [3:0] WR_A      = 4'd5;
    localparam logic [3:0] WR_DR     = 4'd6;
    localparam logic [3:0] WR_AC     = 4'd7;
    localparam logic [3:0] WR_R      = 4'd8;
    localparam logic [3:0] WR_SUM    = 4'd9;
    localparam logic [3:0] WR_DRAM   = 4'd10;
    localparam logic [3:0] WR_CLRAC  = 4'd11;
    // Codes at or above this value are reserved
    localparam logic [3:0] WR_RSVD_MIN = 4'd12;

    // inc_en bit positions
    localparam int unsigned INC_I  = 0;
    localparam int unsigned INC_J  = 1;
    localparam int unsigned INC_K  = 2;
    localparam int unsigned INC_AR = 3;

    // DRAM write handshake states
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } hs_state_t;

    // True for codes that decode to nothing and must be reported as dropped
    function automatic logic is_reserved(input logic [3:0] code);
        return (code >= WR_RSVD_MIN);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dram_wr_hs.sv
// ============================================================================
// Module      : dram_wr_hs
// Description : DRAM write request/acknowledge handshake. Captures address
//               and data on a start strobe, holds the request until ack.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module dram_wr_hs #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_ack,
    output logic              o_dram_we,
    output logic [ADDR_W-1:0] o_dram_addr,
    output logic [WIDTH-1:0]  o_dram_wdata,
    output logic              o_busy,
    output logic              o_wr_done
);

    import bus_pkg::*;

    hs_state_t         r_state;
    hs_state_t         w_next_state;
    logic              w_capture;
    logic              w_ack_seen;
    logic [ADDR_W-1:0] r_addr;
    logic [WIDTH-1:0]  r_data;
    logic              r_done;

    // State register
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: start leaves IDLE, ack returns to it; no timeout
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:     if (i_start) w_next_state = ST_WAIT_ACK;
            ST_WAIT_ACK: if (i_ack)   w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
    end

    // Output decode: request and busy are the WAIT_ACK state itself
    always_comb begin
        o_busy     = (r_state == ST_WAIT_ACK);
        o_dram_we  = (r_state == ST_WAIT_ACK);
        w_capture  = (r_state == ST_IDLE) && i_start;
        w_ack_seen = (r_state == ST_WAIT_ACK) && i_ack;
    end

    // Address/data capture; held stable for the whole request
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_addr <= '0;
            r_data <= '0;
        end else if (w_capture) begin
            r_addr <= i_addr;
            r_data <= i_data;
        end
    end

    // Completion pulse, high in the cycle after ack is accepted
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_ack_seen;
        end
    end

    assign o_dram_addr  = r_addr;
    assign o_dram_wdata = r_data;
    assign o_wr_done    = r_done;

endmodule

`default_nettype wire

// File: rtl/bus_writer.sv
// ============================================================================
// Module      : bus_writer
// Description : Write side of the core bus. Decodes write_en into the
//               working registers, applies increments and launches DRAM
//               writes through the handshake sub-block.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bus_writer #(
    parameter int WIDTH  = 16,
    parameter int ADDR_W = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [3:0]        write_en,
    input  logic [WIDTH-1:0]  busin,
    input  logic [3:0]        inc_en,
    input  logic              dram_ack,
    output logic [WIDTH-1:0]  ar,
    output logic [WIDTH-1:0]  i,
    output logic [WIDTH-1:0]  j,
    output logic [WIDTH-1:0]  k,
    output logic [WIDTH-1:0]  a,
    output logic [WIDTH-1:0]  dr,
    output logic [WIDTH-1:0]  ac,
    output logic [WIDTH-1:0]  r,
    output logic [WIDTH-1:0]  sum,
    output logic              dram_we,
    output logic [ADDR_W-1:0] dram_addr,
    output logic [WIDTH-1:0]  dram_wdata,
    output logic              busy,
    output logic              wr_done,
    output logic              drop
);

    import bus_pkg::*;

    localparam logic [WIDTH-1:0] C_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_ar, r_i, r_j, r_k, r_a, r_dr, r_ac, r_r, r_sum;
    logic             r_drop;
    logic             w_busy;
    logic             w_accept;
    logic             w_drop_next;
    logic             w_start;

    // Writes are only honoured while no DRAM request is outstanding
    always_comb begin
        w_accept    = !w_busy;
        w_start     = w_accept && (write_en == WR_DRAM);
        w_drop_next = is_reserved(write_en) || (w_busy && (write_en != WR_NONE));
    end

    // Index registers: increment first, a same-cycle write overrides it
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_ar <= '0;
            r_i  <= '0;
            r_j  <= '0;
            r_k  <= '0;
        end else begin
            if (inc_en[INC_AR]) r_ar <= r_ar + C_ONE;
            if (inc_en[INC_I])  r_i  <= r_i  + C_ONE;
            if (inc_en[INC_J])  r_j  <= r_j  + C_ONE;
            if (inc_en[INC_K])  r_k  <= r_k  + C_ONE;
            if (w_accept) begin
                if (write_en == WR_AR) r_ar <= busin;
                if (write_en == WR_I)  r_i  <= busin;
                if (write_en == WR_J)  r_j  <= busin;
                if (write_en == WR_K)  r_k  <= busin;
            end
        end
    end

    // Plain data registers, plus the AC clear command
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_a   <= '0;
            r_dr  <= '0;
            r_ac  <= '0;
            r_r   <= '0;
            r_sum <= '0;
        end else if (w_accept) begin
            case (write_en)
                WR_A:     r_a   <= busin;
                WR_DR:    r_dr  <= busin;
                WR_AC:    r_ac  <= busin;
                WR_CLRAC: r_ac  <= '0;
                WR_R:     r_r   <= busin;
                WR_SUM:   r_sum <= busin;
                default:  ;
            endcase
        end
    end

    // Drop pulse, one cycle after an ignored nonzero code
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= w_drop_next;
        end
    end

    dram_wr_hs #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_dram_wr_hs (
        .clock        (clock),
        .resetn       (resetn),
        .i_start      (w_start),
        .i_addr       (r_ar[ADDR_W-1:0]),
        .i_data       (busin),
        .i_ack        (dram_ack),
        .o_dram_we    (dram_we),
        .o_dram_addr  (dram_addr),
        .o_dram_wdata (dram_wdata),
        .o_busy       (w_busy),
        .o_wr_done    (wr_done)
    );

    assign ar   = r_ar;
    assign i    = r_i;
    assign j    = r_j;
    assign k    = r_k;
    assign a    = r_a;
    assign dr   = r_dr;
    assign ac   = r_ac;
    assign r    = r_r;
    assign sum  = r_sum;
    assign busy = w_busy;
    assign drop = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_bus_writer.sv
// ============================================================================
// Module      : tb_bus_writer
// Description : Self-checking bench for bus_writer: directed scenarios then
//               randomized traffic, compared against a behavioural model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bus_writer;

    localparam int W  = 16;
    localparam int AW = 16;

    logic          clock = 1'b0;
    logic          resetn;
    logic [3:0]    write_en;
    logic [W-1:0]  busin;
    logic [3:0]    inc_en;
    logic          dram_ack;
    logic [W-1:0]  ar, i, j, k, a, dr, ac, r, sum;
    logic          dram_we;
    logic [AW-1:0] dram_addr;
    logic [W-1:0]  dram_wdata;
    logic          busy, wr_done, drop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: register file indexed by (write code - 1): AR I J K A DR AC R SUM
    logic [W-1:0]  m_reg [0:8];
    logic          m_busy, m_done, m_drop;
    logic [AW-1:0] m_addr;
    logic [W-1:0]  m_data;

    bus_writer #(.WIDTH(W), .ADDR_W(AW)) dut (
        .clock(clock), .resetn(resetn), .write_en(write_en), .busin(busin),
        .inc_en(inc_en), .dram_ack(dram_ack),
        .ar(ar), .i(i), .j(j), .k(k), .a(a), .dr(dr), .ac(ac), .r(r), .sum(sum),
        .dram_we(dram_we), .dram_addr(dram_addr), .dram_wdata(dram_wdata),
        .busy(busy), .wr_done(wr_done), .drop(drop)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // Behavioural update for one rising edge, from the rules of operation
    task automatic model_edge(input logic rn, input logic [3:0] we, input logic [W-1:0] bin,
                              input logic [3:0] inc, input logic ack);
        logic was_busy;
        int   inc_map [0:3];
        inc_map = '{1, 2, 3, 0};  // inc bit -> register slot (I, J, K, AR)
        if (!rn) begin
            for (int n = 0; n < 9; n++) m_reg[n] = '0;
            m_busy = 0; m_done = 0; m_drop = 0; m_addr = '0; m_data = '0;
            return;
        end
        was_busy = m_busy;
        m_done = was_busy && ack;
        m_drop = (we >= 4'd12) || (was_busy && we != 4'd0);
        if (!was_busy && we == 4'd10) begin
            m_addr = m_reg[0][AW-1:0];
            m_data = bin;
            m_busy = 1;
        end else if (was_busy && ack) begin
            m_busy = 0;
        end
        for (int b = 0; b < 4; b++)
            if (inc[b]) m_reg[inc_map[b]] = m_reg[inc_map[b]] + 1;
        if (!was_busy && we >= 4'd1 && we <= 4'd9) m_reg[we - 1] = bin;
        if (!was_busy && we == 4'd11) m_reg[6] = '0;
    endtask

    task automatic check_all();
        chk("ar", ar, m_reg[0]);   chk("i", i, m_reg[1]);   chk("j", j, m_reg[2]);
        chk("k", k, m_reg[3]);     chk("a", a, m_reg[4]);   chk("dr", dr, m_reg[5]);
        chk("ac", ac, m_reg[6]);   chk("r", r, m_reg[7]);   chk("sum", sum, m_reg[8]);
        chk("dram_we", dram_we, m_busy);
        chk("busy", busy, m_busy);
        chk("dram_addr", dram_addr, m_addr);
        chk("dram_wdata", dram_wdata, m_data);
        chk("wr_done", wr_done, m_done);
        chk("drop", drop, m_drop);
    endtask

    task automatic step(input logic rn, input logic [3:0] we, input logic [W-1:0] bin,
                        input logic [3:0] inc, input logic ack);
        resetn = rn; write_en = we; busin = bin; inc_en = inc; dram_ack = ack;
        @(posedge clock);
        model_edge(rn, we, bin, inc, ack);
        #1;
        cyc++;
        check_all();
    endtask

    initial begin
        logic [3:0] we_r;
        resetn = 0; write_en = 0; busin = 0; inc_en = 0; dram_ack = 0;

        // Reset state
        step(0, 4'd0, 16'h0, 4'b0000, 0);
        step(0, 4'd5, 16'hFFFF, 4'b1111, 1);
        chk("rst_we", dram_we, 1'b0);

        // Plain write to I
        step(1, 4'd2, 16'h1234, 4'b0000, 0);
        chk("tp_i", i, 16'h1234);
        chk("tp_j0", j, 16'h0000);

        // Wrap on I, J write beats J increment
        step(1, 4'd2, 16'hFFFF, 4'b0000, 0);
        step(1, 4'd3, 16'h0042, 4'b0011, 0);
        chk("tp_iwrap", i, 16'h0000);
        chk("tp_jwin", j, 16'h0042);

        // DRAM write with ack delayed
        step(1, 4'd1, 16'h0010, 4'b0000, 0);
        step(1, 4'd10, 16'h00AB, 4'b0000, 0);
        chk("tp_we", dram_we, 1'b1);
        chk("tp_addr", dram_addr, 16'h0010);
        chk("tp_data", dram_wdata, 16'h00AB);
        step(1, 4'd7, 16'h5555, 4'b1000, 0);
        chk("tp_drop_busy", drop, 1'b1);
        chk("tp_ar_inc", ar, 16'h0011);
        chk("tp_addr_hold", dram_addr, 16'h0010);
        chk("tp_ac_hold", ac, 16'h0000);
        step(1, 4'd0, 16'h0, 4'b0000, 0);
        step(1, 4'd0, 16'h0, 4'b0000, 0);
        chk("tp_still_we", dram_we, 1'b1);
        step(1, 4'd0, 16'h0, 4'b0000, 1);
        chk("tp_done", wr_done, 1'b1);
        chk("tp_busy_clr", busy, 1'b0);
        step(1, 4'd0, 16'h0, 4'b0000, 1);
        chk("tp_done_once", wr_done, 1'b0);

        // Reserved code and AC clear
        step(1, 4'd13, 16'hDEAD, 4'b0000, 0);
        chk("tp_drop_rsvd", drop, 1'b1);
        step(1, 4'd7, 16'h0009, 4'b0000, 0);
        chk("tp_ac9", ac, 16'h0009);
        step(1, 4'd11, 16'hFFFF, 4'b0000, 0);
        chk("tp_acclr", ac, 16'h0000);

        // Back-to-back with ack tied high
        step(1, 4'd10, 16'h1111, 4'b0000, 1);
        step(1, 4'd10, 16'h2222, 4'b0000, 1);
        chk("tp_b2b_done", wr_done, 1'b1);
        step(1, 4'd10, 16'h3333, 4'b0000, 1);
        chk("tp_b2b_data", dram_wdata, 16'h3333);
        step(1, 4'd0, 16'h0, 4'b0000, 1);

        // Reset abandons a pending request
        step(1, 4'd10, 16'hBEEF, 4'b0000, 0);
        step(0, 4'd0, 16'h0, 4'b0000, 1);
        chk("tp_rst_we", dram_we, 1'b0);
        chk("tp_rst_done", wr_done, 1'b0);
        chk("tp_rst_ar", ar, 16'h0000);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            we_r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 5) == 0) we_r = 4'd10;
            step(($urandom_range(0, 99) != 0),
                 we_r,
                 ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
                 4'($urandom),
                 ($urandom_range(0, 2) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
